// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding and byte width.
package uart_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the arbiter, bundled as one interface.
// master = arbiter view, slave = producers plus uart_tx view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]                        req_valid;
    logic [uart_ctrl_pkg::DATA_W*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]                        req_ready;
    logic                                    tx_trans;
    logic [uart_ctrl_pkg::DATA_W-1:0]        tx_data;
    logic                                    tx_busy;
    logic                                    done_pulse;
    logic [ID_W-1:0]                         done_id;
    logic                                    timeout_err;
    logic                                    active;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_trans, tx_data, done_pulse, done_id, timeout_err, active
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_trans, tx_data, done_pulse, done_id, timeout_err, active
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first requester above last_grant_i, wrapping
// modulo N_REQ, so the last winner has the lowest priority next time.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             any_req_o
);

    logic [ID_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant_i) + k) % N_REQ);
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                winner_o  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers: round-robin accept, one trans
// pulse per byte, then tracks tx_busy to done or timeout, tagged with the requester id.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ID_W         = $clog2(N_REQ),
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;

    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic [DATA_W-1:0] sel_data;
    logic [N_REQ-1:0]  ready;
    logic              done_pulse;
    logic              timeout_err;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        tx_data_d    = tx_data_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        ready        = '0;
        done_pulse   = 1'b0;
        timeout_err  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    ready[winner] = 1'b1;
                    tx_data_d     = sel_data;
                    cur_id_d      = winner;
                    active_d      = 1'b1;
                    state_d       = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err  = 1'b1;
                    active_d     = 1'b0;
                    last_grant_d = cur_id_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_pulse   = 1'b1;
                    active_d     = 1'b0;
                    last_grant_d = cur_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins: a producer must never see a handshake or an event in a reset cycle.
        if (rst) begin
            ready       = '0;
            done_pulse  = 1'b0;
            timeout_err = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_LAST;
            cur_id_q     <= '0;
            tx_data_q    <= '0;
            cnt_q        <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            tx_data_q    <= tx_data_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_trans    = (state_q == LAUNCH);
    assign bus.tx_data     = tx_data_q;
    assign bus.done_pulse  = done_pulse;
    assign bus.done_id     = cur_id_q;
    assign bus.timeout_err = timeout_err;
    assign bus.active      = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a negedge monitor with a round-robin and
// uart_tx model plus an accept-to-launch scoreboard, driven by directed and random stimulus.
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int N_REQ        = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } xfer_t;

    xfer_t      exp_q[$];
    int         grant_log[$];
    logic [7:0] data_log[$];

    int   cyc        = 0;
    int   accepts    = 0;
    int   dones      = 0;
    int   timeouts   = 0;
    int   last_model = N_REQ - 1;
    int   pend_id    = 0;
    int   trans_cyc  = 0;
    int   frame_left = 0;
    int   frame_len  = 3;
    bit   busy_arb   = 0;
    bit   exp_trans  = 0;
    bit   exp_done   = 0;
    bit   pend       = 0;
    bit   no_busy    = 0;
    bit   busy_next  = 0;
    bit   busy_en    = 1;
    logic [7:0] launched = '0;

    function automatic int rr_model(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    // uart_tx model output: busy changes just after the clock edge, like a register.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.tx_busy = busy_next;
        end
    end

    initial begin : monitor
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] xfer;
        int               w;
        bit               exp_to;
        xfer_t            x;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy_arb   = 0;
                last_model = N_REQ - 1;
                exp_trans  = 0;
                exp_done   = 0;
                pend       = 0;
                frame_left = 0;
                busy_next  = 0;
                exp_q.delete();
                continue;
            end

            exp_ready = '0;
            w = rr_model(bus.req_valid, last_model);
            if (!busy_arb && w >= 0) exp_ready[w] = 1'b1;
            exp_to = pend && no_busy && (cyc - trans_cyc == BUSY_TIMEOUT);
            check("req_ready",   bus.req_ready,   exp_ready);
            check("active",      bus.active,      busy_arb);
            check("tx_trans",    bus.tx_trans,    exp_trans);
            check("done_pulse",  bus.done_pulse,  exp_done);
            check("timeout_err", bus.timeout_err, exp_to);

            exp_trans = 0;
            exp_done  = 0;

            xfer = bus.req_ready & bus.req_valid;
            if (xfer != '0) begin
                check("sb_depth_at_accept", exp_q.size() + int'(pend), 0);
                w = 0;
                for (int i = N_REQ - 1; i >= 0; i--) if (xfer[i]) w = i;
                x.id   = 8'(w);
                x.data = bus.req_data[8*w +: 8];
                exp_q.push_back(x);
                grant_log.push_back(w);
                accepts++;
                busy_arb  = 1;
                exp_trans = 1;
            end

            if (bus.tx_trans) begin
                check("sb_depth_at_trans", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check("tx_data", bus.tx_data, x.data);
                    pend_id = int'(x.id);
                end
                data_log.push_back(bus.tx_data);
                launched  = bus.tx_data;
                pend      = 1;
                trans_cyc = cyc;
                no_busy   = !busy_en;
                if (busy_en) begin
                    busy_next  = 1;
                    frame_left = frame_len;
                end
            end else if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0) begin
                    busy_next = 0;
                    exp_done  = 1;
                end
            end

            if (bus.done_pulse) begin
                check("done_id", bus.done_id, pend_id);
                check("tx_data_hold", bus.tx_data, launched);
                dones++;
            end
            if (bus.timeout_err) begin
                check("timeout_id", bus.done_id, pend_id);
                timeouts++;
            end
            if (bus.done_pulse || bus.timeout_err) begin
                busy_arb   = 0;
                last_model = pend_id;
                pend       = 0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic wait_accepts(input int target, input string tag);
        int k = 0;
        while (accepts < target && k < 400) begin
            step();
            k++;
        end
        check(tag, int'(accepts >= target), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy_arb || pend || exp_q.size() != 0) && k < 400) begin
            step();
            k++;
        end
        check(tag, int'(!busy_arb && !pend && exp_q.size() == 0), 1);
    endtask

    task automatic set_data(input int base_val);
        for (int i = 0; i < N_REQ; i++) bus.req_data[8*i +: 8] = 8'(base_val + i);
    endtask

    int order2[5] = '{0, 1, 2, 3, 0};
    int order3[3] = '{2, 0, 2};

    initial begin : main
        int base;
        int t0;
        int a0;
        int d0;
        int k;

        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_req_ready",  bus.req_ready,   0);
        check("rst_tx_trans",   bus.tx_trans,    0);
        check("rst_tx_data",    bus.tx_data,     0);
        check("rst_done_pulse", bus.done_pulse,  0);
        check("rst_done_id",    bus.done_id,     0);
        check("rst_timeout",    bus.timeout_err, 0);
        check("rst_active",     bus.active,      0);
        step();

        // Single byte from requester 0
        base = grant_log.size();
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 4'b0001;
        wait_accepts(accepts + 1, "t1_accept");
        bus.req_valid = '0;
        wait_idle("t1_idle");
        check("t1_log_len", grant_log.size(), base + 1);
        check("t1_grant",   grant_log[base], 0);
        check("t1_txd",     data_log[base],  8'hA5);

        // All requesters held: full rotation from a fresh reset
        do_reset();
        base = grant_log.size();
        set_data(8'h10);
        bus.req_valid = 4'b1111;
        wait_accepts(accepts + 5, "t2_accept");
        bus.req_valid = '0;
        wait_idle("t2_idle");
        check("t2_log_len", grant_log.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_grant", grant_log[base + i], order2[i]);
            check("t2_txd",   data_log[base + i],  8'h10 + order2[i]);
        end

        // Wrap past id3 after a grant to id2
        do_reset();
        base = grant_log.size();
        set_data(8'h40);
        bus.req_valid = 4'b0100;
        wait_accepts(accepts + 1, "t3_accept_a");
        bus.req_valid = 4'b0101;
        wait_accepts(accepts + 2, "t3_accept_b");
        bus.req_valid = '0;
        wait_idle("t3_idle");
        check("t3_log_len", grant_log.size(), base + 3);
        for (int i = 0; i < 3; i++) check("t3_grant", grant_log[base + i], order3[i]);

        // Busy never rises: timeout, then the next request is still served
        busy_en = 0;
        t0      = timeouts;
        base    = grant_log.size();
        bus.req_data[15:8] = 8'h77;
        bus.req_valid      = 4'b0010;
        wait_accepts(accepts + 1, "t4_accept");
        bus.req_valid = '0;
        k = 0;
        while (timeouts == t0 && k < 100) begin
            step();
            k++;
        end
        check("t4_timeout_count", timeouts, t0 + 1);
        @(negedge clk);
        check("t4_active_after", bus.active, 0);
        step();
        busy_en       = 1;
        bus.req_valid = 4'b0001;
        wait_accepts(accepts + 1, "t4_next_accept");
        bus.req_valid = '0;
        wait_idle("t4_idle");
        check("t4_first_grant", grant_log[base],     1);
        check("t4_next_grant",  grant_log[base + 1], 0);

        // Reset in the middle of a frame (WAIT_DONE)
        frame_len = 10;
        bus.req_data[31:24] = 8'h3C;
        bus.req_valid       = 4'b1000;
        wait_accepts(accepts + 1, "t5_accept");
        bus.req_valid = '0;
        step(4);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t5_req_ready",  bus.req_ready,   0);
        check("t5_tx_trans",   bus.tx_trans,    0);
        check("t5_tx_data",    bus.tx_data,     0);
        check("t5_done_pulse", bus.done_pulse,  0);
        check("t5_timeout",    bus.timeout_err, 0);
        check("t5_done_id",    bus.done_id,     0);
        check("t5_active",     bus.active,      0);
        step();
        rst       = 1'b0;
        frame_len = 3;
        base      = grant_log.size();
        set_data(8'h50);
        bus.req_valid = 4'b1001;
        wait_accepts(accepts + 2, "t5_accept_after");
        bus.req_valid = '0;
        wait_idle("t5_idle");
        check("t5_first_grant",  grant_log[base],     0);
        check("t5_second_grant", grant_log[base + 1], 3);

        // Random valid/data patterns through the scoreboard
        a0 = accepts;
        d0 = dones;
        t0 = timeouts;
        for (int p = 0; p < 200; p++) begin
            frame_len     = int'($urandom_range(1, 6));
            bus.req_valid = N_REQ'($urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++) bus.req_data[8*i +: 8] = 8'($urandom);
            step(int'($urandom_range(1, 4)));
        end
        bus.req_valid = '0;
        wait_idle("rand_idle");
        check("rand_done_eq_accept", dones - d0, accepts - a0);
        check("rand_no_timeout",     timeouts - t0, 0);
        check("rand_sb_empty",       exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
